// File: rtl/coin_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : coin_ctrl_if
//  Description : Control / status link between coin_ctrl and the coffee
//                machine data path (coin counter + registered comparator).
//  Revision    : 1.0 - initial release
// ============================================================================
interface coin_ctrl_if ();
  logic       cnt_en;   // one-cycle counter increment
  logic       cnt_clr;  // synchronous counter clear
  logic       eql_grt;  // credit >= price, one cycle behind sum
  logic [3:0] sum;      // current coin count

  // Controller side
  modport master (
    output cnt_en,
    output cnt_clr,
    input  eql_grt,
    input  sum
  );

  // Data path side
  modport slave (
    input  cnt_en,
    input  cnt_clr,
    output eql_grt,
    output sum
  );
endinterface : coin_ctrl_if
`default_nettype wire

// File: rtl/coin_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : coin_ctrl
//  Description : Coffee machine control unit. Synchronises and edge-detects
//                the raw coin sensor, counts coins through the data path,
//                sequences dispense and counter clear. All outputs are
//                registered.
//  Options     : define CANCEL_EN to add the cancel button / refund path.
//  Revision    : 1.0 - initial release
// ============================================================================
module coin_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,  // >= 2
  parameter int unsigned DISP_CYCLES = 8,  // >= 1
  parameter int unsigned CLR_CYCLES  = 2   // >= 2
) (
  input  logic        clk,
  input  logic        rst_n,
  coin_ctrl_if.master dp_if,
  input  logic        coin_in_i,
  output logic        dispense_o,
  output logic        busy_o,
  output logic        reject_o
`ifdef CANCEL_EN
  ,
  input  logic        cancel_in_i,
  output logic        refund_o,
  output logic [3:0]  refund_amt_o
`endif
);

  localparam int unsigned DISP_W = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;
  localparam int unsigned CLR_W  = (CLR_CYCLES  > 1) ? $clog2(CLR_CYCLES)  : 1;
  localparam logic [DISP_W-1:0] DISP_LAST = DISP_W'(DISP_CYCLES - 1);
  localparam logic [CLR_W-1:0]  CLR_LAST  = CLR_W'(CLR_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CREDIT   = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_CLEAR    = 2'd3
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] coin_sync_q;
  logic                   coin_last_q;
  logic                   w_coin_pulse;
  logic [DISP_W-1:0]      disp_cnt_q;
  logic [CLR_W-1:0]       clr_cnt_q;
  logic                   cnt_en_q;
  logic                   cnt_clr_q;
  logic                   dispense_q;
  logic                   busy_q;
  logic                   reject_q;

  // Coin sensor synchroniser plus a delayed copy of the last stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coin_sync_q <= '0;
      coin_last_q <= 1'b0;
    end else begin
      coin_sync_q <= {coin_sync_q[SYNC_STAGES-2:0], coin_in_i};
      coin_last_q <= coin_sync_q[SYNC_STAGES-1];
    end
  end

  assign w_coin_pulse = coin_sync_q[SYNC_STAGES-1] & ~coin_last_q;

`ifdef CANCEL_EN
  logic [SYNC_STAGES-1:0] cancel_sync_q;
  logic                   cancel_last_q;
  logic                   w_cancel_pulse;
  logic                   refund_q;
  logic [3:0]             refund_amt_q;

  // Cancel button synchroniser, identical in structure to the coin path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cancel_sync_q <= '0;
      cancel_last_q <= 1'b0;
    end else begin
      cancel_sync_q <= {cancel_sync_q[SYNC_STAGES-2:0], cancel_in_i};
      cancel_last_q <= cancel_sync_q[SYNC_STAGES-1];
    end
  end

  assign w_cancel_pulse = cancel_sync_q[SYNC_STAGES-1] & ~cancel_last_q;
  assign refund_o       = refund_q;
  assign refund_amt_o   = refund_amt_q;
`endif

  // Main sequencer; every output is a register updated alongside the state.
  // cnt_clr resets high so the counter is held at zero for the whole reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      disp_cnt_q   <= '0;
      clr_cnt_q    <= '0;
      cnt_en_q     <= 1'b0;
      cnt_clr_q    <= 1'b1;
      dispense_q   <= 1'b0;
      busy_q       <= 1'b0;
      reject_q     <= 1'b0;
`ifdef CANCEL_EN
      refund_q     <= 1'b0;
      refund_amt_q <= 4'h0;
`endif
    end else begin
      cnt_en_q <= 1'b0;
      reject_q <= 1'b0;
`ifdef CANCEL_EN
      refund_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          // Drops the clear left over from reset; credit is zero here.
          cnt_clr_q <= 1'b0;
          if (w_coin_pulse) begin
            cnt_en_q <= 1'b1;
            state_q  <= ST_CREDIT;
          end
        end

        ST_CREDIT: begin
          if (dp_if.eql_grt) begin
            // Price reached: a coin arriving now is not counted.
            state_q    <= ST_DISPENSE;
            dispense_q <= 1'b1;
            busy_q     <= 1'b1;
            disp_cnt_q <= '0;
            reject_q   <= w_coin_pulse;
          end
`ifdef CANCEL_EN
          else if (w_cancel_pulse && (dp_if.sum != 4'h0)) begin
            // Cancel beats a simultaneous coin; refund the captured credit.
            state_q      <= ST_CLEAR;
            cnt_clr_q    <= 1'b1;
            busy_q       <= 1'b1;
            clr_cnt_q    <= '0;
            refund_q     <= 1'b1;
            refund_amt_q <= dp_if.sum;
            reject_q     <= w_coin_pulse;
          end
`endif
          else if (w_coin_pulse) begin
            // Saturate at 15 coins instead of wrapping the counter.
            if (dp_if.sum != 4'hF) begin
              cnt_en_q <= 1'b1;
            end else begin
              reject_q <= 1'b1;
            end
          end
        end

        ST_DISPENSE: begin
          reject_q <= w_coin_pulse;
          if (disp_cnt_q == DISP_LAST) begin
            state_q    <= ST_CLEAR;
            dispense_q <= 1'b0;
            cnt_clr_q  <= 1'b1;
            clr_cnt_q  <= '0;
          end else begin
            disp_cnt_q <= disp_cnt_q + DISP_W'(1);
          end
        end

        ST_CLEAR: begin
          // eql_grt is stale while the counter and comparator flush.
          reject_q <= w_coin_pulse;
          if (clr_cnt_q == CLR_LAST) begin
            state_q   <= ST_IDLE;
            cnt_clr_q <= 1'b0;
            busy_q    <= 1'b0;
          end else begin
            clr_cnt_q <= clr_cnt_q + CLR_W'(1);
          end
        end

        default: begin
          state_q    <= ST_IDLE;
          dispense_q <= 1'b0;
          busy_q     <= 1'b0;
          cnt_clr_q  <= 1'b1;
        end
      endcase
    end
  end

  assign dp_if.cnt_en  = cnt_en_q;
  assign dp_if.cnt_clr = cnt_clr_q;
  assign dispense_o    = dispense_q;
  assign busy_o        = busy_q;
  assign reject_o      = reject_q;

endmodule : coin_ctrl
`default_nettype wire

// File: tb/tb_coin_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_coin_ctrl
//  Description : Self-checking bench for coin_ctrl with a price-3 data path
//                model (4-bit counter + registered comparator).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_coin_ctrl;

  localparam int SYNC = 2;
  localparam int DISP = 8;
  localparam int CLR  = 2;
  localparam int MAXC = 400;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic coin_in = 1'b0;
  logic dispense, busy, reject;
`ifdef CANCEL_EN
  logic       cancel_in = 1'b0;
  logic       refund;
  logic [3:0] refund_amt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  coin_ctrl_if dp_if ();

  coin_ctrl #(
    .SYNC_STAGES (SYNC),
    .DISP_CYCLES (DISP),
    .CLR_CYCLES  (CLR)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dp_if        (dp_if),
    .coin_in_i    (coin_in),
    .dispense_o   (dispense),
    .busy_o       (busy),
    .reject_o     (reject)
`ifdef CANCEL_EN
    ,
    .cancel_in_i  (cancel_in),
    .refund_o     (refund),
    .refund_amt_o (refund_amt)
`endif
  );

  always #5 clk = ~clk;

  // Data path model: wrapping 4-bit coin counter, comparator registered once.
  int         price    = 3;
  logic       load     = 1'b0;
  logic [3:0] load_val = 4'h0;
  logic [3:0] dp_sum   = 4'h0;
  logic       dp_eql   = 1'b0;

  always @(posedge clk) begin
    if (load)                dp_sum <= load_val;
    else if (dp_if.cnt_clr)  dp_sum <= 4'h0;
    else if (dp_if.cnt_en)   dp_sum <= dp_sum + 4'h1;
    dp_eql <= (int'(dp_sum) >= price);
  end
  assign dp_if.sum     = dp_sum;
  assign dp_if.eql_grt = dp_eql;

  // Stimulus schedule (input level per cycle) and captured output trace.
  logic       sc     [MAXC];
  logic       t_en   [MAXC];
  logic       t_clr  [MAXC];
  logic       t_disp [MAXC];
  logic       t_busy [MAXC];
  logic       t_rej  [MAXC];
  logic [3:0] t_sum  [MAXC];
`ifdef CANCEL_EN
  logic       scan   [MAXC];
  logic       t_ref  [MAXC];
  logic [3:0] t_amt  [MAXC];
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sched();
    for (int i = 0; i < MAXC; i++) begin
      sc[i] = 1'b0;
`ifdef CANCEL_EN
      scan[i] = 1'b0;
`endif
    end
  endtask

  task automatic add_coin(input int start, input int len);
    for (int i = start; i < start + len && i < MAXC; i++) sc[i] = 1'b1;
  endtask

`ifdef CANCEL_EN
  task automatic add_cancel(input int start, input int len);
    for (int i = start; i < start + len && i < MAXC; i++) scan[i] = 1'b1;
  endtask
`endif

  // Entry k of the trace is sampled just after the clock edge that follows
  // applying schedule entry k, so a rise at entry r is counted at r+SYNC.
  task automatic run_sched(input int n);
    for (int k = 0; k < n; k++) begin
      coin_in = sc[k];
`ifdef CANCEL_EN
      cancel_in = scan[k];
`endif
      tick();
      t_en[k]   = dp_if.cnt_en;
      t_clr[k]  = dp_if.cnt_clr;
      t_disp[k] = dispense;
      t_busy[k] = busy;
      t_rej[k]  = reject;
      t_sum[k]  = dp_if.sum;
`ifdef CANCEL_EN
      t_ref[k]  = refund;
      t_amt[k]  = refund_amt;
`endif
    end
    coin_in = 1'b0;
`ifdef CANCEL_EN
    cancel_in = 1'b0;
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_tests++; if (dp_if.cnt_clr !== 1'b1) begin n_fail++; $display("FAIL reset_cnt_clr: got %b expected 1", dp_if.cnt_clr); end
    n_tests++; if (dp_if.cnt_en !== 1'b0) begin n_fail++; $display("FAIL reset_cnt_en: got %b expected 0", dp_if.cnt_en); end
    n_tests++; if (dispense !== 1'b0) begin n_fail++; $display("FAIL reset_dispense: got %b expected 0", dispense); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++; if (reject !== 1'b0) begin n_fail++; $display("FAIL reset_reject: got %b expected 0", reject); end
    n_tests++; if (dp_if.sum !== 4'h0) begin n_fail++; $display("FAIL reset_sum: got %0d expected 0", dp_if.sum); end
    rst_n = 1'b1;
    tick();
    n_tests++; if (dp_if.cnt_clr !== 1'b0) begin n_fail++; $display("FAIL release_cnt_clr: got %b expected 0", dp_if.cnt_clr); end
  endtask

  task automatic test_coin_dispense();
    int r [3];
    int pos, n, s, d, en_cnt, rej_cnt, both, bmis, disp_len, clr_len;
    clear_sched();
    pos = 2;
    for (int i = 0; i < 3; i++) begin
      r[i] = pos;
      add_coin(pos, $urandom_range(3, 8));
      pos += 20 + $urandom_range(0, 6);
    end
    n = r[2] + 40;
    run_sched(n);
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (t_en[r[i] + SYNC] !== 1'b1) begin
        n_fail++; $display("FAIL coin_latency[%0d]: cnt_en=%b at edge+%0d expected 1", i, t_en[r[i] + SYNC], SYNC + 1);
      end
    end
    en_cnt = 0; rej_cnt = 0; both = 0; bmis = 0; s = -1; d = -1;
    for (int k = 0; k < n; k++) begin
      if (t_en[k] === 1'b1) en_cnt++;
      if (t_rej[k] === 1'b1) rej_cnt++;
      if (t_en[k] === 1'b1 && t_clr[k] === 1'b1) both++;
      if (t_busy[k] !== (t_disp[k] | t_clr[k])) bmis++;
      if (s < 0 && t_sum[k] == 4'd3) s = k;
      if (d < 0 && t_disp[k] === 1'b1) d = k;
    end
    disp_len = 0; clr_len = 0;
    if (d >= 0) begin
      for (int k = d; k < n && t_disp[k] === 1'b1; k++) disp_len++;
      for (int k = d + disp_len; k < n && t_clr[k] === 1'b1; k++) clr_len++;
    end
    n_tests++; if (en_cnt != 3) begin n_fail++; $display("FAIL coin_en_count: got %0d expected 3", en_cnt); end
    n_tests++; if (rej_cnt != 0) begin n_fail++; $display("FAIL coin_reject_count: got %0d expected 0", rej_cnt); end
    n_tests++; if (both != 0) begin n_fail++; $display("FAIL en_clr_overlap: got %0d cycles expected 0", both); end
    n_tests++; if (bmis != 0) begin n_fail++; $display("FAIL busy_tracking: got %0d bad cycles expected 0", bmis); end
    n_tests++;
    if (s < 0 || d < s || d - s > 3) begin
      n_fail++; $display("FAIL dispense_start: sum=3 at %0d dispense at %0d expected within 3", s, d);
    end
    n_tests++; if (disp_len != DISP) begin n_fail++; $display("FAIL dispense_len: got %0d expected %0d", disp_len, DISP); end
    n_tests++; if (clr_len != CLR) begin n_fail++; $display("FAIL clear_len: got %0d expected %0d", clr_len, CLR); end
    n_tests++; if (t_sum[n-1] !== 4'h0) begin n_fail++; $display("FAIL sum_after_clear: got %0d expected 0", t_sum[n-1]); end
    n_tests++; if (t_busy[n-1] !== 1'b0) begin n_fail++; $display("FAIL idle_after_clear: busy=%b expected 0", t_busy[n-1]); end
  endtask

  task automatic test_reject_in_dispense();
    int r [3];
    int pos, r4, n, en_cnt, rej_cnt, disp_cnt;
    clear_sched();
    pos = 2;
    for (int i = 0; i < 3; i++) begin
      r[i] = pos;
      add_coin(pos, (i == 2) ? 2 : $urandom_range(2, 6));
      pos += 14 + $urandom_range(0, 4);
    end
    // Third coin is counted at r[2]+SYNC and dispense starts 3 cycles later;
    // this offset places the extra coin inside the busy window.
    r4 = r[2] + 4 + $urandom_range(0, DISP + CLR - 1);
    add_coin(r4, 2);
    n = r4 + 30;
    run_sched(n);
    en_cnt = 0; rej_cnt = 0; disp_cnt = 0;
    for (int k = 0; k < n; k++) begin
      if (t_en[k] === 1'b1) en_cnt++;
      if (t_rej[k] === 1'b1) rej_cnt++;
      if (t_disp[k] === 1'b1) disp_cnt++;
    end
    n_tests++; if (t_rej[r4 + SYNC] !== 1'b1) begin n_fail++; $display("FAIL busy_coin_reject: got %b expected 1 (offset %0d)", t_rej[r4 + SYNC], r4 - r[2]); end
    n_tests++; if (rej_cnt != 1) begin n_fail++; $display("FAIL busy_reject_count: got %0d expected 1", rej_cnt); end
    n_tests++; if (en_cnt != 3) begin n_fail++; $display("FAIL busy_en_count: got %0d expected 3", en_cnt); end
    n_tests++; if (disp_cnt != DISP) begin n_fail++; $display("FAIL busy_dispense_cycles: got %0d expected %0d", disp_cnt, DISP); end
    n_tests++; if (t_sum[n-1] !== 4'h0) begin n_fail++; $display("FAIL busy_sum_end: got %0d expected 0", t_sum[n-1]); end
  endtask

  task automatic test_saturate();
    int v, c, x, pos, n, last_r, en_cnt, rej_cnt, disp_cnt;
    v = $urandom_range(12, 14);
    c = 15 - v;
    x = $urandom_range(1, 2);
    price = 16;
    load_val = 4'(v);
    load = 1'b1;
    tick();
    load = 1'b0;
    clear_sched();
    pos = 2; last_r = 2;
    for (int i = 0; i < c + x; i++) begin
      add_coin(pos, 3);
      last_r = pos;
      pos += 10;
    end
    n = pos + 10;
    run_sched(n);
    en_cnt = 0; rej_cnt = 0; disp_cnt = 0;
    for (int k = 0; k < n; k++) begin
      if (t_en[k] === 1'b1) en_cnt++;
      if (t_rej[k] === 1'b1) rej_cnt++;
      if (t_disp[k] === 1'b1) disp_cnt++;
    end
    n_tests++; if (en_cnt != c) begin n_fail++; $display("FAIL sat_en_count: got %0d expected %0d", en_cnt, c); end
    n_tests++; if (rej_cnt != x) begin n_fail++; $display("FAIL sat_reject_count: got %0d expected %0d", rej_cnt, x); end
    n_tests++;
    if (t_rej[last_r + SYNC] !== 1'b1 || t_en[last_r + SYNC] !== 1'b0) begin
      n_fail++; $display("FAIL sat_last_coin: reject=%b cnt_en=%b expected 1/0", t_rej[last_r + SYNC], t_en[last_r + SYNC]);
    end
    n_tests++; if (t_sum[n-1] !== 4'hF) begin n_fail++; $display("FAIL sat_sum: got %0d expected 15", t_sum[n-1]); end
    n_tests++; if (disp_cnt != 0) begin n_fail++; $display("FAIL sat_dispense: got %0d cycles expected 0", disp_cnt); end
    rst_n = 1'b0;
    tick();
    tick();
    price = 3;
    n_tests++; if (dp_if.sum !== 4'h0) begin n_fail++; $display("FAIL sat_reset_clear: sum=%0d expected 0", dp_if.sum); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_dispense();
    int seen, en_cnt;
    for (int i = 0; i < 2; i++) begin
      coin_in = 1'b1;
      repeat ($urandom_range(2, 5)) tick();
      coin_in = 1'b0;
      repeat (12) tick();
    end
    coin_in = 1'b1;
    tick();
    tick();
    coin_in = 1'b0;
    seen = 0;
    for (int k = 0; k < 100 && seen < 4; k++) begin
      tick();
      if (dispense === 1'b1) seen++;
    end
    n_tests++; if (seen != 4) begin n_fail++; $display("FAIL mid_reset_wait: saw %0d dispense cycles expected 4", seen); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (dispense !== 1'b0) begin n_fail++; $display("FAIL mid_reset_dispense: got %b expected 0", dispense); end
    n_tests++; if (dp_if.cnt_clr !== 1'b1) begin n_fail++; $display("FAIL mid_reset_cnt_clr: got %b expected 1", dp_if.cnt_clr); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy: got %b expected 0", busy); end
    repeat ($urandom_range(1, 3)) tick();
    n_tests++; if (dp_if.sum !== 4'h0) begin n_fail++; $display("FAIL mid_reset_sum: got %0d expected 0", dp_if.sum); end
    rst_n = 1'b1;
    tick();
    en_cnt = 0;
    coin_in = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) coin_in = 1'b0;
      tick();
      if (dp_if.cnt_en === 1'b1) en_cnt++;
    end
    n_tests++; if (en_cnt != 1) begin n_fail++; $display("FAIL post_reset_en: got %0d expected 1", en_cnt); end
    n_tests++; if (dp_if.sum !== 4'h1) begin n_fail++; $display("FAIL post_reset_sum: got %0d expected 1", dp_if.sum); end
  endtask

`ifdef CANCEL_EN
  task automatic test_cancel();
    int r0, r1, rc, n, ref_cnt, clr_len, clr_cnt;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    clear_sched();
    r0 = 2;
    r1 = r0 + 12 + $urandom_range(0, 5);
    rc = r1 + 12 + $urandom_range(0, 5);
    add_coin(r0, 3);
    add_coin(r1, 3);
    add_cancel(rc, 3);
    n = rc + 20;
    run_sched(n);
    ref_cnt = 0;
    for (int k = 0; k < n; k++) if (t_ref[k] === 1'b1) ref_cnt++;
    clr_len = 0;
    for (int k = rc + SYNC; k < n && t_clr[k] === 1'b1; k++) clr_len++;
    n_tests++; if (t_ref[rc + SYNC] !== 1'b1) begin n_fail++; $display("FAIL cancel_refund: got %b expected 1", t_ref[rc + SYNC]); end
    n_tests++; if (ref_cnt != 1) begin n_fail++; $display("FAIL cancel_refund_count: got %0d expected 1", ref_cnt); end
    n_tests++; if (t_amt[rc + SYNC] !== 4'd2) begin n_fail++; $display("FAIL cancel_amt: got %0d expected 2", t_amt[rc + SYNC]); end
    n_tests++; if (clr_len != CLR) begin n_fail++; $display("FAIL cancel_clr_len: got %0d expected %0d", clr_len, CLR); end
    n_tests++; if (t_sum[n-1] !== 4'h0) begin n_fail++; $display("FAIL cancel_sum: got %0d expected 0", t_sum[n-1]); end
    clear_sched();
    add_cancel(2, 3);
    n = 20;
    run_sched(n);
    ref_cnt = 0; clr_cnt = 0;
    for (int k = 0; k < n; k++) begin
      if (t_ref[k] === 1'b1) ref_cnt++;
      if (t_clr[k] === 1'b1) clr_cnt++;
    end
    n_tests++; if (ref_cnt != 0) begin n_fail++; $display("FAIL cancel_empty_refund: got %0d expected 0", ref_cnt); end
    n_tests++; if (clr_cnt != 0) begin n_fail++; $display("FAIL cancel_empty_clr: got %0d expected 0", clr_cnt); end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_coin_dispense();
    test_reject_in_dispense();
    test_saturate();
    test_reset_mid_dispense();
`ifdef CANCEL_EN
    test_cancel();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_coin_ctrl
`default_nettype wire
